// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : State encoding, instruction field positions and ALU select codes
//            shared by the ALU sequencer slice.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Instruction field positions (10-bit word)
  localparam int LD_BIT  = 9;
  localparam int S_HI    = 8;
  localparam int S_LO    = 6;
  localparam int CIN_BIT = 5;
  localparam int RD_HI   = 4;
  localparam int RD_LO   = 3;
  localparam int RB_HI   = 1;
  localparam int RB_LO   = 0;
  localparam int IMM_HI  = 8;
  localparam int IMM_LO  = 5;

  // ALU select codes, bit order {s0,s1,s2,cin}
  localparam logic [3:0] ADD = 4'b1000;
  localparam logic [3:0] SUB = 4'b0101;
  localparam logic [3:0] AND = 4'b0010;
  localparam logic [3:0] XOR = 4'b1010;
  localparam logic [3:0] SET = 4'b1011;

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
// ============================================================================
// Module   : alu_seq_if
// Brief    : Instruction, ALU and result channels of the ALU sequencer.
//            master = sequencer side, slave = environment (issuer, ALU,
//            result consumer).
//            Optional: ALU_SEQ_FLAGS_EN adds the flag_z signal.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_seq_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [0:2] alu_s;
  logic       alu_cin;
  logic [3:0] alu_f;
  logic       result_valid;
  logic       result_ready;
  logic [3:0] result;
`ifdef ALU_SEQ_FLAGS_EN
  logic       flag_z;
`endif

  modport master (
`ifdef ALU_SEQ_FLAGS_EN
    output flag_z,
`endif
    input  instr_valid, instr, alu_f, result_ready,
    output instr_ready, alu_a, alu_b, alu_s, alu_cin, result_valid, result
  );

  modport slave (
`ifdef ALU_SEQ_FLAGS_EN
    input  flag_z,
`endif
    output instr_valid, instr, alu_f, result_ready,
    input  instr_ready, alu_a, alu_b, alu_s, alu_cin, result_valid, result
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq_regfile.sv
// ============================================================================
// Module   : alu_seq_regfile
// Brief    : NREG x W register file, two combinational read ports, one
//            synchronous write port, asynchronous active-low clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_regfile #(
  parameter int NREG = 4,
  parameter int W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [W-1:0]            wdata,
  input  logic [$clog2(NREG)-1:0] raddr_a,
  input  logic [$clog2(NREG)-1:0] raddr_b,
  output logic [W-1:0]            rdata_a,
  output logic [W-1:0]            rdata_b
);
  localparam int AW = $clog2(NREG);

  logic [W-1:0] w_regs [NREG];

  generate
    for (genvar i = 0; i < NREG; i++) begin : g_reg
      logic [W-1:0] r_q;
      // One storage word, written when addressed
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_q <= '0;
        else if (we && (waddr == AW'(i)))
          r_q <= wdata;
      end
      assign w_regs[i] = r_q;
    end
  endgenerate

  assign rdata_a = w_regs[raddr_a];
  assign rdata_b = w_regs[raddr_b];

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Multi-cycle issuing controller for the external 4-bit ALU.
//            Accepts load / ALU-op instructions, drives the ALU for one EXEC
//            cycle, writes the result back and returns it over a handshake.
//            Optional: define ALU_SEQ_FLAGS_EN to add the flag_z output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.master bus
);
  localparam int AW = $clog2(NREG);

  state_t         r_state;
  logic           r_instr_ready;
  logic           r_result_valid;
  logic [W-1:0]   r_result;
  logic [AW-1:0]  r_rd;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [0:2]     r_alu_s;
  logic           r_alu_cin;

  logic           w_accept;
  logic           w_is_ld;
  logic           w_we;
  logic [AW-1:0]  w_waddr;
  logic [W-1:0]   w_wdata;
  logic [W-1:0]   w_rdata_a;
  logic [W-1:0]   w_rdata_b;
  logic           w_unused;

  // Reserved instruction bit has no function
  assign w_unused = bus.instr[2];

  assign w_accept = bus.instr_valid && r_instr_ready;
  assign w_is_ld  = bus.instr[LD_BIT];

  // Loads write at the accept edge, ALU ops at the end of EXEC
  assign w_we    = (w_accept && w_is_ld) || (r_state == EXEC);
  assign w_waddr = (r_state == EXEC) ? r_rd : bus.instr[RD_HI:RD_LO];
  assign w_wdata = (r_state == EXEC) ? bus.alu_f : bus.instr[IMM_HI:IMM_LO];

  // Operands are read from the incoming word; no write can land between
  // the accept edge and EXEC, so registering them here is equivalent.
  alu_seq_regfile #(
    .NREG (NREG),
    .W    (W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (w_we),
    .waddr   (w_waddr),
    .wdata   (w_wdata),
    .raddr_a (bus.instr[RD_HI:RD_LO]),
    .raddr_b (bus.instr[RB_HI:RB_LO]),
    .rdata_a (w_rdata_a),
    .rdata_b (w_rdata_b)
  );

  // Control FSM with registered handshake and ALU drive outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_instr_ready  <= 1'b1;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_rd           <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_s        <= '0;
      r_alu_cin      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_instr_ready <= 1'b0;
            r_rd          <= bus.instr[RD_HI:RD_LO];
            if (w_is_ld) begin
              r_result       <= bus.instr[IMM_HI:IMM_LO];
              r_result_valid <= 1'b1;
              r_state        <= RESP;
            end else begin
              r_alu_a   <= w_rdata_a;
              r_alu_b   <= w_rdata_b;
              r_alu_s   <= bus.instr[S_HI:S_LO];
              r_alu_cin <= bus.instr[CIN_BIT];
              r_state   <= EXEC;
            end
          end
        end
        EXEC: begin
          r_result       <= bus.alu_f;
          r_result_valid <= 1'b1;
          r_alu_a        <= '0;
          r_alu_b        <= '0;
          r_alu_s        <= '0;
          r_alu_cin      <= 1'b0;
          r_state        <= RESP;
        end
        RESP: begin
          if (bus.result_ready) begin
            r_result_valid <= 1'b0;
            r_instr_ready  <= 1'b1;
            r_state        <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_flag_z;

  // Zero flag tracks the most recent write-back (loads included)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_flag_z <= 1'b0;
    else if (w_we)
      r_flag_z <= (w_wdata == '0);
  end

  assign bus.flag_z = r_flag_z;
`endif

  assign bus.instr_ready  = r_instr_ready;
  assign bus.result_valid = r_result_valid;
  assign bus.result       = r_result;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_s        = r_alu_s;
  assign bus.alu_cin      = r_alu_cin;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer with a behavioural 4-bit
//            ALU between the alu_* ports and a result scoreboard.
//            Optional: ALU_SEQ_FLAGS_EN enables flag_z checks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [3:0] sb [$];

  alu_seq_if bus ();

  alu_sequencer #(
    .NREG (4),
    .W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU, select key {s0,s1,s2,cin}
  function automatic logic [3:0] alu_model(input logic [0:2] s, input logic cin,
                                           input logic [3:0] a, input logic [3:0] b);
    logic [3:0] key;
    key = {s[0], s[1], s[2], cin};
    case (key)
      4'b1000: return a + b;
      4'b0101: return a - b;
      4'b0010: return a & b;
      4'b1010: return a ^ b;
      4'b1011: return a;
      default: return a | b;
    endcase
  endfunction

  assign bus.alu_f = alu_model(bus.alu_s, bus.alu_cin, bus.alu_a, bus.alu_b);

  // Drive one instruction, complete its result handshake, pop the scoreboard.
  // exec_snap: ALU drive just after accept; resp_snap: ALU drive in RESP.
  task automatic send(input logic [9:0] ins, input logic [3:0] exp,
                      output int lat, output logic [3:0] got, output logic [3:0] want,
                      output logic [11:0] exec_snap, output logic [11:0] resp_snap);
    int wait_cnt;
    sb.push_back(exp);
    @(negedge clk);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    wait_cnt = 0;
    while (!bus.instr_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    exec_snap = {bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin};
    lat = 1;
    while (!bus.result_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got       = bus.result;
    resp_snap = {bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin};
    want      = (sb.size() > 0) ? sb.pop_front() : 4'hx;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.instr_ready, bus.result_valid, bus.result} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_hs: got rdy/vld/res=%b/%b/%h required 1/0/0",
               bus.instr_ready, bus.result_valid, bus.result);
    end
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_alu: got %h required 000",
               {bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin});
    end
`ifdef ALU_SEQ_FLAGS_EN
    n_checks++;
    if (bus.flag_z !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flag_z: got %b required 0", bus.flag_z);
    end
`endif
  endtask

  task automatic test_load();
    int lat; logic [3:0] got, want; logic [11:0] es, rs;
    send(10'b1010101000, 4'h5, lat, got, want, es, rs);
    n_checks++;
    if (got !== want || lat != 1) begin
      n_fail++;
      $display("FAIL load_r1: got %h lat %0d required %h lat 1", got, lat, want);
    end
    send(10'b1001110000, 4'h3, lat, got, want, es, rs);
    n_checks++;
    if (got !== want || lat != 1) begin
      n_fail++;
      $display("FAIL load_r2: got %h lat %0d required %h lat 1", got, lat, want);
    end
  endtask

  task automatic test_add();
    int lat; logic [3:0] got, want; logic [11:0] es, rs;
    send(10'b0100001010, 4'h8, lat, got, want, es, rs);
    n_checks++;
    if (got !== want || lat != 2) begin
      n_fail++;
      $display("FAIL add: got %h lat %0d required %h lat 2", got, lat, want);
    end
    n_checks++;
    if (es !== {4'h5, 4'h3, 3'b100, 1'b0}) begin
      n_fail++;
      $display("FAIL add_exec_drive: got %h required %h", es, {4'h5, 4'h3, 3'b100, 1'b0});
    end
    n_checks++;
    if (rs !== 12'h000) begin
      n_fail++;
      $display("FAIL add_resp_drive: got %h required 000", rs);
    end
    // SET R1 reads R1 back through the ALU
    send(10'b0101101000, 4'h8, lat, got, want, es, rs);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL add_writeback: got %h required %h", got, want);
    end
  endtask

  task automatic test_logic_ops();
    int lat; logic [3:0] got, want; logic [11:0] es, rs;
    send(10'b1010101000, 4'h5, lat, got, want, es, rs);
    send(10'b0010101010, 4'h2, lat, got, want, es, rs);
    n_checks++;
    if (got !== want || lat != 2) begin
      n_fail++;
      $display("FAIL sub: got %h lat %0d required %h lat 2", got, lat, want);
    end
    send(10'b1010101000, 4'h5, lat, got, want, es, rs);
    send(10'b0101001010, 4'h6, lat, got, want, es, rs);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL xor: got %h required %h", got, want);
    end
    // AND R1(=6),R2(=3)
    send(10'b0001001010, 4'h2, lat, got, want, es, rs);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL and: got %h required %h", got, want);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [3:0] got, want; logic [11:0] es, rs;
    send(10'b1111101000, 4'hF, lat, got, want, es, rs);
    send(10'b1000111000, 4'h1, lat, got, want, es, rs);
`ifdef ALU_SEQ_FLAGS_EN
    n_checks++;
    if (bus.flag_z !== 1'b0) begin
      n_fail++;
      $display("FAIL flag_z_nonzero: got %b required 0", bus.flag_z);
    end
`endif
    send(10'b0100001011, 4'h0, lat, got, want, es, rs);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL wrap_add: got %h required %h", got, want);
    end
`ifdef ALU_SEQ_FLAGS_EN
    n_checks++;
    if (bus.flag_z !== 1'b1) begin
      n_fail++;
      $display("FAIL flag_z_wrap: got %b required 1", bus.flag_z);
    end
`endif
  endtask

  task automatic test_backpressure();
    int lat; logic [3:0] got, want; logic [11:0] es, rs;
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.instr        = 10'b1100100000;   // load R0 = 9
    bus.instr_valid  = 1'b1;
    sb.push_back(4'h9);
    @(posedge clk);
    #1;
    bus.instr = 10'b1010000000;          // load R0 = 4, must be ignored
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus.result_valid, bus.result, bus.instr_ready} !== {1'b1, 4'h9, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld/res/rdy=%b/%h/%b required 1/9/0",
                 i, bus.result_valid, bus.result, bus.instr_ready);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.instr_valid  = 1'b0;
    bus.result_ready = 1'b1;
    got  = bus.result;
    want = (sb.size() > 0) ? sb.pop_front() : 4'hx;
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL bp_result: got %h required %h", got, want);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.result_valid, bus.instr_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got vld/rdy=%b/%b required 0/1",
               bus.result_valid, bus.instr_ready);
    end
    // SET R0 confirms the ignored load did not write
    send(10'b0101100000, 4'h9, lat, got, want, es, rs);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL bp_ignored_instr: got %h required %h", got, want);
    end
  endtask

  task automatic test_reset_mid_exec();
    int lat; int stray; logic [3:0] got, want; logic [11:0] es, rs;
    send(10'b1010101000, 4'h5, lat, got, want, es, rs);
    send(10'b1001110000, 4'h3, lat, got, want, es, rs);
    @(negedge clk);
    bus.instr       = 10'b0100001010;    // ADD R1,R2, aborted
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    n_checks++;
    if (bus.alu_a !== 4'h5) begin
      n_fail++;
      $display("FAIL rst_exec_entered: got alu_a %h required 5", bus.alu_a);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.result_valid, bus.result, bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin} !== 17'h0) begin
      n_fail++;
      $display("FAIL rst_outputs: got %h required 00000",
               {bus.result_valid, bus.result, bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin});
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.result_valid) stray++;
    end
    n_checks++;
    if (stray != 0 || bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release: got stray %0d rdy %b required 0 1", stray, bus.instr_ready);
    end
    send(10'b0101101000, 4'h0, lat, got, want, es, rs);
    n_checks++;
    if (got !== want || lat != 2) begin
      n_fail++;
      $display("FAIL rst_no_writeback: got %h lat %0d required %h lat 2", got, lat, want);
    end
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst_n            = 1'b1;
    bus.instr_valid  = 1'b0;
    bus.instr        = '0;
    bus.result_ready = 1'b1;
    test_reset();
    test_load();
    test_add();
    test_logic_ops();
    test_wrap();
    test_backpressure();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

`default_nettype wire
